// File: rtl/ym_saa_bus_sequencer_if.sv
// Request/response and chip-bus signal bundle for the YM/SAA bus sequencer.
// The requester side (decoder or bench) uses master; the sequencer uses slave.
interface ym_saa_bus_sequencer_if;
  logic       req;
  logic       req_wr;
  logic [1:0] req_chip;
  logic       req_a0;
  logic [7:0] req_data;
  logic       busy;
  logic       overrun;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ymcs1_n;
  logic       ymcs2_n;
  logic       saacs_n;
  logic       ymrd_n;
  logic       ymwr_n;
  logic       saawr_n;
  logic       yma0;
  logic       saaa0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    output req, req_wr, req_chip, req_a0, req_data, d_in,
    input  busy, overrun, rd_data, rd_valid,
    input  ymcs1_n, ymcs2_n, saacs_n, ymrd_n, ymwr_n, saawr_n,
    input  yma0, saaa0, d_out, d_oe
  );

  modport slave (
    input  req, req_wr, req_chip, req_a0, req_data, d_in,
    output busy, overrun, rd_data, rd_valid,
    output ymcs1_n, ymcs2_n, saacs_n, ymrd_n, ymwr_n, saawr_n,
    output yma0, saaa0, d_out, d_oe
  );
endinterface

// File: rtl/ym_saa_bus_sequencer.sv
// Turns decoded YM1/YM2/SAA access requests into timed chip-bus cycles
// (setup, strobe, hold, recovery) with a one-deep pending request slot.
module ym_saa_bus_sequencer #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 6,
  parameter int HOLD_CYC     = 2,
  parameter int RECOVERY_CYC = 4
) (
  input logic                   fclk,
  input logic                   ayres_n,
  ym_saa_bus_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] chip;
    logic       a0;
    logic [7:0] data;
  } txn_t;

  localparam logic [1:0] CHIP_SAA  = 2'd2;
  localparam logic [1:0] CHIP_NONE = 2'd3;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVERY_CYC - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  txn_t       act_reg, act_next;
  txn_t       pend_reg, pend_next;
  logic       pend_valid_reg, pend_valid_next;
  txn_t       req_txn;
  logic       req_ok, last_cyc, req_launch, drop;
  logic       in_bus, drive_bus, strobe_on, is_ym, rd_done;

  logic [2:0] cs_n_reg;
  logic       ymrd_n_reg, ymwr_n_reg, saawr_n_reg;
  logic       yma0_reg, saaa0_reg, d_oe_reg;
  logic [7:0] d_out_reg, rd_data_reg;
  logic       busy_reg, overrun_reg, rd_valid_reg;

  always_comb begin
    req_txn         = {bus.req_wr, bus.req_chip, bus.req_a0, bus.req_data};
    req_ok          = bus.req && (bus.req_chip != CHIP_NONE);
    last_cyc        = (cnt_reg == 4'd0);
    state_next      = state_reg;
    cnt_next        = last_cyc ? cnt_reg : cnt_reg - 4'd1;
    act_next        = act_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    req_launch      = 1'b0;
    drop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_ok) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          act_next   = req_txn;
          req_launch = 1'b1;
        end
      end
      SETUP: begin
        if (last_cyc) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
        end
      end
      STROBE: begin
        if (last_cyc) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
        end
      end
      HOLD: begin
        if (last_cyc) begin
          state_next = RECOVER;
          cnt_next   = RECOVER_LD;
        end
      end
      RECOVER: begin
        if (last_cyc) begin
          // The pending slot has priority; an empty slot lets a same-edge
          // request start without a wasted IDLE cycle.
          if (pend_valid_reg) begin
            state_next      = SETUP;
            cnt_next        = SETUP_LD;
            act_next        = pend_reg;
            pend_valid_next = 1'b0;
          end else if (req_ok) begin
            state_next = SETUP;
            cnt_next   = SETUP_LD;
            act_next   = req_txn;
            req_launch = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (req_ok && !req_launch) begin
      if (!pend_valid_reg || (state_reg == RECOVER && last_cyc)) begin
        pend_next       = req_txn;
        pend_valid_next = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // SAA reads have no bus strobe, so they run the timing with the bus idle.
    in_bus    = state_next inside {SETUP, STROBE, HOLD};
    drive_bus = in_bus && !(act_next.chip == CHIP_SAA && !act_next.wr);
    strobe_on = drive_bus && (state_next == STROBE);
    is_ym     = (act_next.chip != CHIP_SAA);
    rd_done   = (state_reg == STROBE) && last_cyc && !act_reg.wr;
  end

  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      act_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      ymrd_n_reg     <= 1'b1;
      ymwr_n_reg     <= 1'b1;
      saawr_n_reg    <= 1'b1;
      yma0_reg       <= 1'b0;
      saaa0_reg      <= 1'b0;
      d_out_reg      <= 8'h00;
      d_oe_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      rd_data_reg    <= 8'h00;
      rd_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      act_reg        <= act_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      ymrd_n_reg     <= !(strobe_on && is_ym && !act_next.wr);
      ymwr_n_reg     <= !(strobe_on && is_ym && act_next.wr);
      saawr_n_reg    <= !(strobe_on && !is_ym);
      if (drive_bus && is_ym) begin
        yma0_reg <= act_next.a0;
      end
      if (drive_bus && !is_ym) begin
        saaa0_reg <= act_next.a0;
      end
      d_oe_reg <= in_bus && act_next.wr;
      if (in_bus && act_next.wr) begin
        d_out_reg <= act_next.data;
      end
      busy_reg     <= (state_next != IDLE) || pend_valid_next;
      overrun_reg  <= drop;
      rd_valid_reg <= rd_done;
      if (rd_done) begin
        rd_data_reg <= (act_reg.chip == CHIP_SAA) ? 8'hFF : bus.d_in;
      end
    end
  end

  // One select flop per chip: index 0 = YM1, 1 = YM2, 2 = SAA.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cs
      always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
          cs_n_reg[gi] <= 1'b1;
        end else begin
          cs_n_reg[gi] <= !(drive_bus && (act_next.chip == 2'(gi)));
        end
      end
    end
  endgenerate

  assign bus.ymcs1_n  = cs_n_reg[0];
  assign bus.ymcs2_n  = cs_n_reg[1];
  assign bus.saacs_n  = cs_n_reg[2];
  assign bus.ymrd_n   = ymrd_n_reg;
  assign bus.ymwr_n   = ymwr_n_reg;
  assign bus.saawr_n  = saawr_n_reg;
  assign bus.yma0     = yma0_reg;
  assign bus.saaa0    = saaa0_reg;
  assign bus.d_out    = d_out_reg;
  assign bus.d_oe     = d_oe_reg;
  assign bus.busy     = busy_reg;
  assign bus.overrun  = overrun_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_ym_saa_bus_sequencer.sv
// Self-checking bench for ym_saa_bus_sequencer: vector table, hand-written
// multi-cycle sequences and a random run against a transaction-level model.
module tb_ym_saa_bus_sequencer;

  localparam int SETUP  = 2;
  localparam int STROBE = 6;
  localparam int HOLD   = 2;
  localparam int RECOV  = 4;
  localparam int TLEN   = SETUP + STROBE + HOLD + RECOV;
  localparam int NR     = 2000;

  logic fclk    = 1'b0;
  logic ayres_n = 1'b0;

  ym_saa_bus_sequencer_if bus ();

  ym_saa_bus_sequencer #(
    .SETUP_CYC   (SETUP),
    .STROBE_CYC  (STROBE),
    .HOLD_CYC    (HOLD),
    .RECOVERY_CYC(RECOV)
  ) dut (
    .fclk   (fclk),
    .ayres_n(ayres_n),
    .bus    (bus)
  );

  always #5 fclk = ~fclk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       wr;
    logic [1:0] chip;
    logic       a0;
    logic [7:0] data;
    logic [7:0] din;
    logic [2:0] cs_low;   // bit0 ymcs1, bit1 ymcs2, bit2 saacs
    logic [2:0] stb_low;  // bit0 ymrd, bit1 ymwr, bit2 saawr
    logic       doe;
    logic       rv;
    logic [7:0] rdata;
    logic [1:0] a0_exp;   // {yma0, saaa0} from cycle 1 on
    logic       bsy;
  } vec_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] chip;
    logic       a0;
    logic [7:0] data;
  } req_t;

  vec_t vecs [8];

  // Transaction-level reference model state
  req_t       cur, slot;
  int         cur_s;
  int         free_at = -1000;
  bit         has_cur = 1'b0;
  bit         slot_full = 1'b0;
  bit         ovr_exp = 1'b0;
  logic       ym_a0_m, saa_a0_m;
  logic [7:0] din_hist [0:NR+64];

  function automatic logic [11:0] snap();
    return {bus.ymcs1_n, bus.ymcs2_n, bus.saacs_n, bus.ymrd_n, bus.ymwr_n,
            bus.saawr_n, bus.yma0, bus.saaa0, bus.d_oe, bus.busy,
            bus.overrun, bus.rd_valid};
  endfunction

  function automatic logic [11:0] vecx(logic [2:0] cs, logic [2:0] stb,
                                       logic ya0, logic sa0, logic doe,
                                       logic bsy, logic ovr, logic rv);
    return {~cs[0], ~cs[1], ~cs[2], ~stb[0], ~stb[1], ~stb[2],
            ya0, sa0, doe, bsy, ovr, rv};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_req(input logic r, input logic wr, input logic [1:0] chip,
                           input logic a0, input logic [7:0] data);
    bus.req      = r;
    bus.req_wr   = wr;
    bus.req_chip = chip;
    bus.req_a0   = a0;
    bus.req_data = data;
  endtask

  task automatic apply_reset();
    @(negedge fclk);
    ayres_n = 1'b0;
    repeat (2) @(negedge fclk);
    ayres_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [11:0] ev;
    bit in_cs, in_stb;
    $display("vec %0d: chip=%0d wr=%0d a0=%0d data=%h din=%h",
             idx, v.chip, v.wr, v.a0, v.data, v.din);
    drive_req(1'b1, v.wr, v.chip, v.a0, v.data);
    bus.d_in = v.din;
    @(posedge fclk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge fclk);
      if (c == 1) bus.req = 1'b0;
      in_cs  = v.bsy && c >= 1 && c <= 10;
      in_stb = v.bsy && c >= 3 && c <= 8;
      ev = vecx(in_cs ? v.cs_low : 3'b000, in_stb ? v.stb_low : 3'b000,
                v.a0_exp[1], v.a0_exp[0], in_cs && v.doe,
                v.bsy && c <= 14, 1'b0, v.rv && c == 9);
      check("vec_outs", idx * 100 + c, snap(), ev);
      if (in_cs && v.doe) check("vec_d_out", idx * 100 + c, 12'(bus.d_out), 12'(v.data));
      if (v.rv && c == 9) check("vec_rd_data", idx * 100 + c, 12'(bus.rd_data), 12'(v.rdata));
    end
  endtask

  task automatic model_start(input req_t t, input int e);
    cur     = t;
    cur_s   = e;
    has_cur = 1'b1;
    free_at = e + TLEN;
    if (t.chip != 2'd2) ym_a0_m = t.a0;
    else if (t.wr) saa_a0_m = t.a0;
    $display("rand txn edge %0d: chip=%0d wr=%0d a0=%0d data=%h",
             e, t.chip, t.wr, t.a0, t.data);
  endtask

  task automatic model_step(input int e);
    req_t t;
    t = {bus.req_wr, bus.req_chip, bus.req_a0, bus.req_data};
    ovr_exp = 1'b0;
    if (slot_full && e == free_at) begin
      model_start(slot, e);
      slot_full = 1'b0;
    end
    if (bus.req && bus.req_chip != 2'd3) begin
      if (e >= free_at) model_start(t, e);
      else if (!slot_full) begin
        slot = t;
        slot_full = 1'b1;
      end else ovr_exp = 1'b1;
    end
  endtask

  task automatic rand_check(input int e);
    int p;
    bit act, io, csp, stp, rv;
    logic [2:0] cs, stb;
    logic [11:0] ev;
    p   = e - cur_s;
    act = has_cur && p >= 0 && p < TLEN;
    io  = act && !(cur.chip == 2'd2 && !cur.wr);
    csp = io && p < SETUP + STROBE + HOLD;
    stp = io && p >= SETUP && p < SETUP + STROBE;
    rv  = act && !cur.wr && p == SETUP + STROBE;
    cs  = 3'b000;
    stb = 3'b000;
    if (csp) cs = (cur.chip == 2'd0) ? 3'b001 : (cur.chip == 2'd1) ? 3'b010 : 3'b100;
    if (stp) stb = (cur.chip == 2'd2) ? 3'b100 : (cur.wr ? 3'b010 : 3'b001);
    ev = vecx(cs, stb, ym_a0_m, saa_a0_m, csp && cur.wr, act || slot_full, ovr_exp, rv);
    check("rand_outs", e, snap(), ev);
    if (rv) check("rand_rd_data", e, 12'(bus.rd_data),
                  12'((cur.chip == 2'd2) ? 8'hFF : din_hist[cur_s + SETUP + STROBE]));
    if (csp && cur.wr) check("rand_d_out", e, 12'(bus.d_out), 12'(cur.data));
  endtask

  initial begin
    logic [11:0] idle_v;
    logic [11:0] ev;
    bit in_cs;

    vecs[0] = '{1'b1, 2'd0, 1'b0, 8'h5A, 8'h00, 3'b001, 3'b010, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1};
    vecs[1] = '{1'b0, 2'd1, 1'b1, 8'h00, 8'h80, 3'b010, 3'b001, 1'b0, 1'b1, 8'h80, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 2'd2, 1'b1, 8'h00, 8'h55, 3'b000, 3'b000, 1'b0, 1'b1, 8'hFF, 2'b10, 1'b1};
    vecs[3] = '{1'b1, 2'd2, 1'b1, 8'h1C, 8'h00, 3'b100, 3'b100, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[4] = '{1'b1, 2'd3, 1'b0, 8'hAA, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 1'b1, 8'hC3, 8'h00, 3'b001, 3'b010, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 1'b0, 8'h00, 8'h3C, 3'b001, 3'b001, 1'b0, 1'b1, 8'h3C, 2'b01, 1'b1};
    vecs[7] = '{1'b1, 2'd1, 1'b0, 8'h00, 8'h00, 3'b010, 3'b010, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1};

    idle_v = vecx(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_req(1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    bus.d_in = 8'h00;

    // Reset state
    repeat (3) @(negedge fclk);
    check("reset_outs", 0, snap(), idle_v);
    check("reset_d_out", 0, 12'(bus.d_out), 12'h000);
    check("reset_rd_data", 0, 12'(bus.rd_data), 12'h000);
    ayres_n = 1'b1;

    // Single-transaction vectors
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Three back-to-back requests: run, store, drop
    apply_reset();
    $display("seq back-to-back: SAA adr 1C, SAA data 03, YM1 data FF");
    drive_req(1'b1, 1'b1, 2'd2, 1'b0, 8'h1C);
    @(posedge fclk);
    for (int c = 1; c <= 32; c++) begin
      @(negedge fclk);
      in_cs = (c >= 1 && c <= 10) || (c >= 15 && c <= 24);
      ev = vecx(in_cs ? 3'b100 : 3'b000,
                ((c >= 3 && c <= 8) || (c >= 17 && c <= 22)) ? 3'b100 : 3'b000,
                1'b0, c >= 15, in_cs, c <= 28, c == 3, 1'b0);
      check("b2b_outs", c, snap(), ev);
      if (in_cs) check("b2b_d_out", c, 12'(bus.d_out), (c <= 10) ? 12'h01C : 12'h003);
      if (c == 1) drive_req(1'b1, 1'b1, 2'd2, 1'b1, 8'h03);
      else if (c == 2) drive_req(1'b1, 1'b1, 2'd0, 1'b1, 8'hFF);
      else bus.req = 1'b0;
    end

    // Asynchronous reset during STROBE with the slot full
    apply_reset();
    $display("seq reset mid-strobe: YM1 write 77 then YM2 read pending");
    drive_req(1'b1, 1'b1, 2'd0, 1'b1, 8'h77);
    @(posedge fclk);
    @(negedge fclk);
    drive_req(1'b1, 1'b0, 2'd1, 1'b0, 8'h00);
    @(posedge fclk);
    @(negedge fclk);
    bus.req = 1'b0;
    @(posedge fclk);
    @(negedge fclk);
    check("rst_pre_outs", 3, snap(),
          vecx(3'b001, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    #2 ayres_n = 1'b0;
    #1 check("rst_async_outs", 0, snap(), idle_v);
    @(negedge fclk);
    @(negedge fclk);
    ayres_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge fclk);
      check("rst_after_outs", c, snap(), idle_v);
    end

    // Random traffic against the transaction-level model
    apply_reset();
    ym_a0_m  = 1'b0;
    saa_a0_m = 1'b0;
    for (int e = 0; e < NR + 40; e++) begin
      if (e > 0) begin
        @(negedge fclk);
        rand_check(e - 1);
      end
      drive_req((e < NR) && ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      bus.d_in = 8'($urandom_range(0, 255));
      din_hist[e] = bus.d_in;
      model_step(e);
      @(posedge fclk);
    end
    @(negedge fclk);
    rand_check(NR + 39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
